// File: rtl/fetch_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// fetch_sequencer_pkg : shared state encoding and width definitions
// Revision: 1.0
// ============================================================================
package fetch_sequencer_pkg;

    localparam int DEFAULT_NUMBER_OF_PC_REGISTERS = 16;

    // Decoded instruction field widths, shared with the decode controller.
    localparam int OPERATION_TYPE_WIDTH = 2;
    localparam int OPCODE_WIDTH         = 4;
    localparam int ADDR_WIDTH           = 4;
    localparam int DEFAULT_PC_WIDTH     = $clog2(DEFAULT_NUMBER_OF_PC_REGISTERS);
    localparam int WORD_SIZE            = 16;
    localparam int DECODED_INSTR_WIDTH  = OPERATION_TYPE_WIDTH + OPCODE_WIDTH
                                        + 3 * ADDR_WIDTH + DEFAULT_PC_WIDTH + WORD_SIZE;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_HALT    = 3'd4,
        ST_ERROR   = 3'd5
    } fetch_state_t;

    function automatic logic is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/issue_watchdog.sv
`default_nettype none
// ============================================================================
// issue_watchdog : clearable up-counter flagging the START_TIMEOUT-th count
// Revision: 1.0
// ============================================================================
module issue_watchdog #(
    parameter int START_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic terminal
);

    localparam int                 c_cnt_w = $clog2(START_TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(START_TIMEOUT - 1);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (count_en && (r_count != c_last)) begin
            r_count <= r_count + 1'b1;
        end
    end

    // High when the count being taken this edge is the START_TIMEOUT-th one.
    assign terminal = count_en && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// fetch_sequencer : fetch/issue/retire sequencer between PC ROM and decoder
// Revision: 1.0
// ============================================================================
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int NUMBER_OF_PC_REGISTERS = DEFAULT_NUMBER_OF_PC_REGISTERS,
    parameter int PC_WIDTH               = $clog2(NUMBER_OF_PC_REGISTERS),
    parameter int INSTR_WIDTH            = 32,
    parameter int COUNT_WIDTH            = 16,
    parameter int START_TIMEOUT          = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    output logic [PC_WIDTH-1:0]    pc_address,
    input  logic [INSTR_WIDTH-1:0] instr_in,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic                   start,
    input  logic                   busy,
    input  logic                   done,
    input  logic [PC_WIDTH-1:0]    next_pc,
    output logic                   halted,
    output logic                   timeout_error,
    output logic [COUNT_WIDTH-1:0] retired_count
);

    fetch_state_t r_state;
    logic         w_wd_clear;
    logic         w_wd_count;
    logic         w_wd_terminal;
    logic         w_pc_invalid;
    logic         w_halt_req;

    // Clearing during FETCH gives every ISSUE entry a fresh count.
    assign w_wd_clear = (r_state == ST_FETCH);
    assign w_wd_count = (r_state == ST_ISSUE) && !busy;

    issue_watchdog #(
        .START_TIMEOUT (START_TIMEOUT)
    ) u_issue_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear    (w_wd_clear),
        .count_en (w_wd_count),
        .terminal (w_wd_terminal)
    );

    generate
        if (is_pow2(NUMBER_OF_PC_REGISTERS)) begin : g_all_in_range
            assign w_pc_invalid = 1'b0;
        end else begin : g_range_check
            localparam logic [PC_WIDTH:0] c_pc_limit = (PC_WIDTH + 1)'(NUMBER_OF_PC_REGISTERS);
            assign w_pc_invalid = ({1'b0, next_pc} >= c_pc_limit);
        end
    endgenerate

    assign w_halt_req = w_pc_invalid || (next_pc == pc_address);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            pc_address    <= '0;
            instr_out     <= '0;
            start         <= 1'b0;
            halted        <= 1'b0;
            timeout_error <= 1'b0;
            retired_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    start <= 1'b0;
                    if (enable) begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    instr_out <= instr_in;
                    start     <= 1'b1;
                    r_state   <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (busy) begin
                        start   <= 1'b0;
                        r_state <= ST_EXECUTE;
                    end else if (w_wd_terminal) begin
                        start         <= 1'b0;
                        timeout_error <= 1'b1;
                        r_state       <= ST_ERROR;
                    end
                end
                ST_EXECUTE: begin
                    start <= 1'b0;
                    if (done) begin
                        if (retired_count != {COUNT_WIDTH{1'b1}}) begin
                            retired_count <= retired_count + 1'b1;
                        end
                        if (w_halt_req) begin
                            halted  <= 1'b1;
                            r_state <= ST_HALT;
                        end else begin
                            pc_address <= next_pc;
                            r_state    <= enable ? ST_FETCH : ST_IDLE;
                        end
                    end
                end
                ST_HALT, ST_ERROR: begin
                    start <= 1'b0;
                end
                default: begin
                    start   <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// tb_fetch_sequencer : randomized transaction-level check of fetch_sequencer
// Revision: 1.0
// ============================================================================
module tb_fetch_sequencer;

    localparam int NPC  = 12;
    localparam int PCW  = 4;
    localparam int IW   = 32;
    localparam int CW   = 2;
    localparam int TMO  = 15;
    localparam int CMAX = (1 << CW) - 1;

    logic           clk     = 1'b0;
    logic           rst     = 1'b0;
    logic           enable  = 1'b0;
    logic           busy    = 1'b0;
    logic           done    = 1'b0;
    logic [PCW-1:0] next_pc = '0;
    logic [PCW-1:0] pc_address;
    logic [IW-1:0]  instr_in;
    logic [IW-1:0]  instr_out;
    logic           start;
    logic           halted;
    logic           timeout_error;
    logic [CW-1:0]  retired_count;

    logic [IW-1:0]  rom [16];

    int n_checks = 0;
    int n_fail   = 0;

    // Architectural model: current PC, instructions retired, halt flag.
    int m_pc     = 0;
    int m_total  = 0;
    bit m_halted = 1'b0;

    always #5 clk = ~clk;

    assign instr_in = rom[pc_address];

    fetch_sequencer #(
        .NUMBER_OF_PC_REGISTERS (NPC),
        .PC_WIDTH               (PCW),
        .INSTR_WIDTH            (IW),
        .COUNT_WIDTH            (CW),
        .START_TIMEOUT          (TMO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .pc_address    (pc_address),
        .instr_in      (instr_in),
        .instr_out     (instr_out),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .next_pc       (next_pc),
        .halted        (halted),
        .timeout_error (timeout_error),
        .retired_count (retired_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_retired();
        return (m_total > CMAX) ? CMAX : m_total;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_pc"},      32'(pc_address),    32'd0);
        check_eq({tag, "_instr"},   instr_out,          32'd0);
        check_eq({tag, "_start"},   32'(start),         32'd0);
        check_eq({tag, "_halted"},  32'(halted),        32'd0);
        check_eq({tag, "_timeout"}, 32'(timeout_error), 32'd0);
        check_eq({tag, "_retired"}, 32'(retired_count), 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0; enable = 1'b0; busy = 1'b0; done = 1'b0;
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        m_pc = 0; m_total = 0; m_halted = 1'b0;
    endtask

    task automatic wait_start(output int lat);
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (start) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic do_instr(input int exp_lat, input int bdly, input int ddly, input int npc,
                            input bit drop_en, input bit overlap);
        int lat;
        int hi;
        wait_start(lat);
        check_eq("issue_latency", 32'(lat), 32'(exp_lat));
        if (lat < 0) return;
        check_eq("fetch_pc", 32'(pc_address), 32'(m_pc));
        check_eq("instr_out", instr_out, rom[m_pc]);
        hi = 0;
        for (int i = 0; i < bdly; i++) begin
            if (start) hi++;
            if (i == bdly - 1) begin
                busy = 1'b1;
                if (overlap) begin
                    done    = 1'b1;
                    next_pc = PCW'((npc + 5) % NPC);
                end
            end
            @(posedge clk); #1;
        end
        busy = 1'b0; done = 1'b0;
        check_eq("start_width", 32'(hi), 32'(bdly));
        check_eq("start_drop", 32'(start), 32'd0);
        check_eq("no_early_retire", 32'(retired_count), 32'(exp_retired()));
        if (drop_en) enable = 1'b0;
        for (int i = 0; i < ddly; i++) begin
            if (i == ddly - 1) begin
                done    = 1'b1;
                next_pc = PCW'(npc);
            end
            @(posedge clk); #1;
        end
        done = 1'b0;
        m_total++;
        if (npc >= NPC || npc == m_pc) m_halted = 1'b1;
        else m_pc = npc;
        check_eq("retired", 32'(retired_count), 32'(exp_retired()));
        check_eq("pc_after", 32'(pc_address), 32'(m_pc));
        check_eq("halted", 32'(halted), 32'(m_halted));
        if (m_halted) begin
            for (int i = 0; i < 4; i++) begin
                @(posedge clk); #1;
                check_eq("halt_no_start", 32'(start), 32'd0);
            end
        end else if (drop_en) begin
            for (int i = 0; i < 3; i++) begin
                @(posedge clk); #1;
                check_eq("parked_no_start", 32'(start), 32'd0);
            end
        end
    endtask

    initial begin
        int lat;
        int npc;
        int cyc;
        for (int i = 0; i < 16; i++) rom[i] = $urandom;
        rom[0] = 32'hA5A5_0001;

        // Reset then run the first instruction from address 0.
        apply_reset();
        enable = 1'b1;
        do_instr(2, 2, 3, 1, 1'b0, 1'b0);

        // Random chained instructions; retired_count saturates along the way.
        for (int k = 0; k < 6; k++) begin
            npc = $urandom_range(0, NPC - 1);
            if (npc == m_pc) npc = (npc + 1) % NPC;
            do_instr(1, $urandom_range(1, 5), $urandom_range(1, 4), npc, 1'b0,
                     ($urandom_range(0, 2) == 0));
        end
        do_instr(1, 1, 2, (m_pc + 3) % NPC, 1'b0, 1'b1);

        // Enable dropped in EXECUTE: completes, parks, then fetches next_pc.
        npc = (m_pc + 1) % NPC;
        do_instr(1, 2, 2, npc, 1'b1, 1'b0);
        enable = 1'b1;
        if (m_pc == 4) do_instr(2, 1, 1, 6, 1'b0, 1'b0);
        else           do_instr(2, 1, 1, 4, 1'b0, 1'b0);
        if (m_pc != 4) do_instr(1, 1, 1, 4, 1'b0, 1'b0);

        // Self-loop halt at PC 4, then stray handshakes are ignored.
        do_instr(1, 3, 2, 4, 1'b0, 1'b0);
        busy = 1'b1; done = 1'b1; next_pc = 4'd2;
        @(posedge clk); #1;
        busy = 1'b0; done = 1'b0;
        check_eq("halt_sticky_pc", 32'(pc_address), 32'd4);
        check_eq("halt_sticky", 32'(halted), 32'd1);

        // Out-of-range next_pc halts without moving the PC.
        apply_reset();
        enable = 1'b1;
        do_instr(2, 1, 1, 13, 1'b0, 1'b0);

        // Start timeout.
        apply_reset();
        enable = 1'b1;
        wait_start(lat);
        check_eq("tmo_latency", 32'(lat), 32'd2);
        cyc = -1;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (timeout_error) begin
                cyc = c;
                break;
            end
        end
        check_eq("tmo_cycles", 32'(cyc), 32'(TMO));
        check_eq("tmo_start", 32'(start), 32'd0);
        busy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        busy = 1'b0;
        check_eq("tmo_sticky", 32'(timeout_error), 32'd1);
        check_eq("tmo_sticky_start", 32'(start), 32'd0);
        check_eq("tmo_not_halted", 32'(halted), 32'd0);

        // Asynchronous reset while start is high.
        apply_reset();
        enable = 1'b1;
        do_instr(2, 1, 1, 7, 1'b0, 1'b0);
        wait_start(lat);
        check_eq("pre_areset_start", 32'(start), 32'd1);
        #3;
        rst = 1'b0;
        #1;
        check_outputs_zero("areset");
        @(negedge clk);
        rst = 1'b1;
        m_pc = 0; m_total = 0; m_halted = 1'b0;
        wait_start(lat);
        check_eq("restart_latency", 32'(lat), 32'd2);
        check_eq("restart_pc", 32'(pc_address), 32'd0);
        check_eq("restart_instr", instr_out, rom[0]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
